// File: rtl/spi_controller.sv
// Burst sequencer for one spiUnit: config latch, divider tick, chip selects, TX/RX streams.
// Optional SPI_CONTROLLER_COMPARE_EN adds a loopback compare flag on compareError.
module spi_controller #(
    parameter int DATAWIDTH = 8,
    parameter int DIVWIDTH  = 16,
    parameter int LENWIDTH  = 8,
    parameter int CSCOUNT   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LENWIDTH-1:0]        length,
    input  logic [$clog2(CSCOUNT)-1:0] csSelect,
    input  logic [DIVWIDTH-1:0]        clockDivider,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic                       msbFirst,
    input  logic                       abort,
    input  logic [DATAWIDTH-1:0]       txData,
    input  logic                       txValid,
    output logic                       txReady,
    output logic [DATAWIDTH-1:0]       rxData,
    output logic                       rxValid,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [CSCOUNT-1:0]         cs_n,
    output logic                       unitClockPolarity,
    output logic                       unitClockPhase,
    output logic                       unitDataDirection,
    output logic                       unitFinalCycle,
    output logic [DATAWIDTH-1:0]       unitDataRegIn,
    output logic                       unitTransmitReady,
    input  logic [DATAWIDTH-1:0]       unitDataReg,
    input  logic                       unitCoreWrite,
    input  logic                       unitCoreRead,
    input  logic                       unitIdle,
    output logic                       compareError
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SHIFT,
        HOLD,
        DONE
    } stateT;

    stateT               state;
    logic [DIVWIDTH-1:0] divCnt;
    logic [DIVWIDTH-1:0] divLatched;
    logic [LENWIDTH-1:0] wordCnt;
    logic                abortPending;
    logic                idleSeen;
    logic                startAccept;

    assign startAccept    = (state == IDLE) && start && (length != '0);
    assign unitFinalCycle = (state != IDLE) && (divCnt == divLatched);
    // abort wins over a same-cycle word so nothing is shifted after it
    assign txReady        = (state == LOAD) && !unitTransmitReady && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
        end else if (state == IDLE) begin
            divCnt <= '0;
        end else if (unitFinalCycle) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + DIVWIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            divLatched        <= '0;
            wordCnt           <= '0;
            abortPending      <= 1'b0;
            idleSeen          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            rxValid           <= 1'b0;
            rxData            <= '0;
            cs_n              <= '1;
            unitClockPolarity <= 1'b0;
            unitClockPhase    <= 1'b0;
            unitDataDirection <= 1'b0;
            unitDataRegIn     <= '0;
            unitTransmitReady <= 1'b0;
        end else begin
            done    <= 1'b0;
            rxValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (startAccept) begin
                        divLatched        <= clockDivider;
                        wordCnt           <= length;
                        unitClockPolarity <= cpol;
                        unitClockPhase    <= cpha;
                        unitDataDirection <= ~msbFirst;
                        cs_n              <= ~(CSCOUNT'(1) << csSelect);
                        busy              <= 1'b1;
                        aborted           <= 1'b0;
                        abortPending      <= 1'b0;
                        idleSeen          <= 1'b0;
                        state             <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= HOLD;
                    end else if (unitFinalCycle) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!unitTransmitReady) begin
                        if (abort) begin
                            aborted <= 1'b1;
                            state   <= HOLD;
                        end else if (txValid) begin
                            unitDataRegIn     <= txData;
                            unitTransmitReady <= 1'b1;
                        end
                    end else begin
                        if (abort) begin
                            abortPending <= 1'b1;
                            aborted      <= 1'b1;
                        end
                        if (unitCoreWrite) begin
                            unitTransmitReady <= 1'b0;
                            state             <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        abortPending <= 1'b1;
                        aborted      <= 1'b1;
                    end
                    if (unitCoreRead) begin
                        rxData  <= unitDataReg;
                        rxValid <= 1'b1;
                        wordCnt <= wordCnt - LENWIDTH'(1);
                        if (wordCnt == LENWIDTH'(1) || abortPending || abort) begin
                            state <= HOLD;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    // one full tick after the unit goes idle before releasing CS
                    if (!idleSeen) begin
                        if (unitIdle) idleSeen <= 1'b1;
                    end else if (unitFinalCycle) begin
                        cs_n  <= '1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_CONTROLLER_COMPARE_EN
    logic [DATAWIDTH-1:0] lastTx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastTx       <= '0;
            compareError <= 1'b0;
        end else begin
            if (startAccept) compareError <= 1'b0;
            if (txValid && txReady) lastTx <= txData;
            if (state == SHIFT && unitCoreRead && unitDataReg != lastTx) begin
                compareError <= 1'b1;
            end
        end
    end
`else
    assign compareError = 1'b0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench for spi_controller with a behavioural spiUnit and a scoreboard.
// Checks stream order, chip selects, tick spacing, latched modes, abort and reset.
module tb_spi_controller;
    localparam int DW = 8;
    localparam int CSN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, txValid, txReady, rxValid, busy, done, aborted;
    logic [7:0] length;
    logic [1:0] csSelect;
    logic [15:0] clockDivider;
    logic cpol, cpha, msbFirst;
    logic [DW-1:0] txData, rxData, unitDataRegIn, unitDataReg;
    logic [CSN-1:0] cs_n;
    logic unitClockPolarity, unitClockPhase, unitDataDirection, unitFinalCycle;
    logic unitTransmitReady, unitCoreWrite, unitCoreRead, unitIdle, compareError;

    spi_controller dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .csSelect(csSelect), .clockDivider(clockDivider),
        .cpol(cpol), .cpha(cpha), .msbFirst(msbFirst), .abort(abort),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .busy(busy), .done(done),
        .aborted(aborted), .cs_n(cs_n),
        .unitClockPolarity(unitClockPolarity), .unitClockPhase(unitClockPhase),
        .unitDataDirection(unitDataDirection), .unitFinalCycle(unitFinalCycle),
        .unitDataRegIn(unitDataRegIn), .unitTransmitReady(unitTransmitReady),
        .unitDataReg(unitDataReg), .unitCoreWrite(unitCoreWrite),
        .unitCoreRead(unitCoreRead), .unitIdle(unitIdle),
        .compareError(compareError)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // behavioural spiUnit: 2 ticks per bit, MISO looped back (optionally inverted)
    bit invertMiso = 0;
    bit uBusy = 0;
    int uCnt = 0;
    logic [DW-1:0] uWord;
    always @(negedge clk) begin
        unitCoreWrite = 1'b0;
        unitCoreRead = 1'b0;
        if (reset) begin
            uBusy = 0;
            unitIdle = 1'b1;
        end else if (!uBusy) begin
            if (unitTransmitReady) begin
                uWord = unitDataRegIn;
                uBusy = 1;
                uCnt = 0;
                unitIdle = 1'b0;
                unitCoreWrite = 1'b1;
            end
        end else if (unitFinalCycle) begin
            uCnt++;
            if (uCnt == 2 * DW) begin
                unitDataReg = invertMiso ? ~uWord : uWord;
                unitCoreRead = 1'b1;
                uBusy = 0;
                unitIdle = 1'b1;
            end
        end
    end

    // reference model state, captured from the spec's acceptance rules
    logic [7:0] txQ[$];
    logic [7:0] expQ[$];
    logic [7:0] rxLog[$];
    int csLat = 0, divLat = 0;
    bit cpolLat = 0, cphaLat = 0, msbLat = 0;
    int acceptCount = 0, rxCount = 0, doneCount = 0;
    bit accFlag = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (start && !busy && length != 0) begin
                csLat = int'(csSelect);
                divLat = int'(clockDivider);
                cpolLat = cpol;
                cphaLat = cpha;
                msbLat = msbFirst;
            end
            if (txValid && txReady) begin
                expQ.push_back(invertMiso ? ~txData : txData);
                acceptCount++;
                accFlag = 1;
            end
        end
    end

    // TX feeder: optional random gaps and one long stall before word stallIdx
    bit randGap = 0;
    int wordIdx = 0, gap = 0, stallLenG = 0;
    always @(negedge clk) begin
        if (accFlag) begin
            accFlag = 0;
            if (txQ.size() > 0) void'(txQ.pop_front());
            wordIdx++;
            if (wordIdx == 1 && stallLenG > 0) gap = stallLenG;
            else gap = randGap ? int'($urandom_range(0, 3)) : 0;
        end
        if (gap > 0) begin
            gap--;
            txValid = 1'b0;
        end else if (txQ.size() > 0) begin
            txValid = 1'b1;
            txData = txQ[0];
        end else begin
            txValid = 1'b0;
        end
    end

    // per-cycle compare process
    bit prevBusy = 0, prevUtr = 0, prevDone = 0;
    logic [DW-1:0] prevDataIn;
    int sinceTick = 0;
    always @(negedge clk) begin
        if (reset) begin
            prevBusy = 0;
            prevUtr = 0;
            prevDone = 0;
        end else begin
            if (busy && !prevBusy) sinceTick = 0;
            chk("cs_legal", (cs_n == 4'hF) || (cs_n == ~(4'(1) << csLat)), 1);
            if (!busy) begin
                chk("idle_cs", cs_n, 4'hF);
                chk("idle_utr", unitTransmitReady, 0);
                chk("idle_tick", unitFinalCycle, 0);
            end else begin
                sinceTick++;
                chk("mode_out", {unitClockPolarity, unitClockPhase, unitDataDirection},
                    {cpolLat, cphaLat, ~msbLat});
                if (unitFinalCycle) begin
                    chk("tick_gap", sinceTick, divLat + 1);
                    sinceTick = 0;
                end
            end
            if (prevUtr && unitTransmitReady) chk("tx_stable", unitDataRegIn, prevDataIn);
            if (rxValid) begin
                chk("rx_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) chk("rx_data", rxData, expQ.pop_front());
                rxLog.push_back(rxData);
                rxCount++;
            end
            if (done) begin
                doneCount++;
                chk("done_busy", busy, 0);
                chk("done_pulse", prevDone, 0);
            end
            prevBusy = busy;
            prevUtr = unitTransmitReady;
            prevDataIn = unitDataRegIn;
            prevDone = done;
        end
    end

    logic [2:0] modeSnap;
    logic abortedSnap, cmpSnap;
    logic [3:0] csSeen;
    int tickGap = 0;

    task automatic runBurst(input int len, input int div, input int cs, input bit cp,
                            input bit ch, input bit msb, input int abortAt,
                            input int stallLen, input bit busyStart);
        int cyc, lastTick, expRx, doneBase, stallCyc;
        bit sawDone, abortSent, csSet, stallChecked;
        logic [3:0] csExp;
        csExp = ~(4'(1) << cs);
        if (txQ.size() == 0) for (int i = 0; i < len; i++) txQ.push_back(8'($urandom));
        @(negedge clk);
        acceptCount = 0;
        rxCount = 0;
        expQ.delete();
        rxLog.delete();
        wordIdx = 0;
        gap = 0;
        stallLenG = stallLen;
        doneBase = doneCount;
        length = 8'(len);
        csSelect = 2'(cs);
        clockDivider = 16'(div);
        cpol = cp;
        cpha = ch;
        msbFirst = msb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cpol = ~cp;
        cpha = ~ch;
        msbFirst = ~msb;
        clockDivider = 16'($urandom);
        csSelect = 2'($urandom);
        length = 8'($urandom);
        if (abortAt < 0) abort = 1'b1;
        cyc = 0;
        lastTick = -1;
        sawDone = 0;
        abortSent = 0;
        csSet = 0;
        stallCyc = 0;
        stallChecked = 0;
        while (cyc < 4000 && !sawDone) begin
            @(negedge clk);
            cyc++;
            abort = 1'b0;
            start = 1'b0;
            if (cyc == 2) begin
                modeSnap = {unitClockPolarity, unitClockPhase, unitDataDirection};
                abortedSnap = aborted;
                cmpSnap = compareError;
            end
            if (busyStart && cyc == 6) begin
                start = 1'b1;
                length = 8'd1;
            end
            if (abortAt > 0 && !abortSent && acceptCount == abortAt && rxCount < abortAt
                && !unitTransmitReady && !rxValid && busy) begin
                abort = 1'b1;
                abortSent = 1;
            end
            if (unitFinalCycle) begin
                if (lastTick >= 0) tickGap = cyc - lastTick;
                lastTick = cyc;
            end
            if (rxValid && !csSet) begin
                csSeen = cs_n;
                csSet = 1;
            end
            if (stallLen > 0 && !stallChecked && acceptCount == 1 && rxCount == 1) begin
                stallCyc++;
                if (stallCyc == 20) begin
                    chk("stall_utr", unitTransmitReady, 0);
                    chk("stall_cs", cs_n, csExp);
                    chk("stall_txready", txReady, 1);
                    stallChecked = 1;
                end
            end
            if (done) sawDone = 1;
        end
        chk("burst_done", sawDone, 1);
        repeat (3) @(negedge clk);
        expRx = (abortAt > 0) ? abortAt : ((abortAt < 0) ? 0 : len);
        chk("rx_count", rxCount, expRx);
        chk("accept_count", acceptCount, expRx);
        chk("done_count", doneCount - doneBase, 1);
        chk("aborted", aborted, abortAt != 0);
        chk("busy_end", busy, 0);
        chk("cs_end", cs_n, 4'hF);
        chk("expq_empty", expQ.size(), 0);
        txQ.delete();
    endtask

    initial begin
        int len, ab, doneBase;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        length = '0;
        csSelect = '0;
        clockDivider = '0;
        cpol = 1'b0;
        cpha = 1'b0;
        msbFirst = 1'b1;
        txValid = 1'b0;
        txData = '0;
        unitDataReg = '0;
        unitCoreWrite = 1'b0;
        unitCoreRead = 1'b0;
        unitIdle = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cs", cs_n, 4'hF);
        chk("rst_rxdata", rxData, 0);
        chk("rst_flags", {done, aborted, rxValid, txReady, unitTransmitReady, unitFinalCycle}, 0);
        chk("rst_modes", {unitClockPolarity, unitClockPhase, unitDataDirection}, 0);
        reset = 1'b0;

        txQ = '{8'hA5, 8'h3C, 8'hFF};
        runBurst(3, 3, 2, 0, 0, 1, 0, 0, 0);
        chk("t1_rx0", rxLog[0], 8'hA5);
        chk("t1_rx1", rxLog[1], 8'h3C);
        chk("t1_rx2", rxLog[2], 8'hFF);
        chk("t1_cs", csSeen, 4'b1011);
        chk("t1_tick", tickGap, 4);

        runBurst(2, 1, 0, 0, 0, 1, 0, 50, 0);
        runBurst(5, 1, 3, 0, 1, 1, 2, 0, 0);

        for (int i = 0; i < 8; i++) begin
            txQ = '{8'h81};
            runBurst(1, 0, i % 4, i[0], i[1], i[2], 0, 0, 0);
            if (i == 0) chk("aborted_cleared", abortedSnap, 0);
            chk("mode_rx", rxLog[0], 8'h81);
            chk("mode_snap", modeSnap, {i[0], i[1], ~i[2]});
        end

        runBurst(2, 3, 1, 0, 0, 1, -1, 0, 0);

        doneBase = doneCount;
        @(negedge clk);
        length = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("len0_busy", busy, 0);
        chk("len0_done", doneCount - doneBase, 0);

        runBurst(3, 0, 1, 1, 0, 1, 0, 0, 1);

        randGap = 1;
        for (int i = 0; i < 20; i++) begin
            len = int'($urandom_range(1, 6));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            runBurst(len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), ab, 0, 0);
        end
        randGap = 0;

        for (int i = 0; i < 3; i++) txQ.push_back(8'($urandom));
        @(negedge clk);
        acceptCount = 0;
        rxCount = 0;
        expQ.delete();
        length = 8'd3;
        csSelect = 2'd0;
        clockDivider = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (acceptCount == 1 && rxCount == 0 && !unitTransmitReady && !rxValid && busy)
                found = 1;
        end
        chk("reset_reached_shift", found, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cs", cs_n, 4'hF);
        chk("mid_rst_rxdata", rxData, 0);
        chk("mid_rst_flags", {done, aborted, rxValid, txReady, unitTransmitReady, unitFinalCycle}, 0);
        chk("mid_rst_modes", {unitClockPolarity, unitClockPhase, unitDataDirection}, 0);
        txQ.delete();
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        runBurst(2, 0, 2, 0, 0, 1, 0, 0, 0);

`ifdef SPI_CONTROLLER_COMPARE_EN
        invertMiso = 1;
        txQ = '{8'h55};
        runBurst(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("cmp_set", compareError, 1);
        chk("cmp_inv_rx", rxLog[0], 8'hAA);
        invertMiso = 0;
        txQ = '{8'h55};
        runBurst(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("cmp_cleared", cmpSnap, 0);
        chk("cmp_loop", compareError, 0);
`else
        chk("cmp_tied", compareError, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
